// File: rtl/sa_tile_engine.sv
// sa_tile_engine: output-stationary matrix-multiply tile engine.
// One result row is built at a time. SA_C column MACs accumulate across K_LEN
// cycles, then the row is rounded, saturated and written back in one WB cycle.

// Per-column datapath: one MAC step plus the round/saturate of the current sum.
module sa_tile_pe #(
    parameter int D_W   = 8,
    parameter int ACC_W = 23,
    parameter int FRAC  = 5
) (
    input  logic signed [D_W-1:0]   a_i,
    input  logic signed [D_W-1:0]   b_i,
    input  logic signed [ACC_W-1:0] acc_i,
    output logic signed [ACC_W-1:0] mac_o,
    output logic signed [D_W-1:0]   q_o
);
    // Rounding offset and clamp bounds, kept one bit wider than the accumulator
    // so that adding the offset can never wrap.
    localparam logic signed [ACC_W:0] RND  = (ACC_W+1)'(1 << (FRAC - 1));
    localparam logic signed [ACC_W:0] SMAX = (ACC_W+1)'((1 << (D_W - 1)) - 1);
    localparam logic signed [ACC_W:0] SMIN = ~SMAX;

    logic signed [2*D_W-1:0] prod;
    logic signed [ACC_W:0]   rnd;

    // Sign-extended product into the accumulator; round half up then clamp.
    always_comb begin
        prod  = $signed({{D_W{a_i[D_W-1]}}, a_i}) * $signed({{D_W{b_i[D_W-1]}}, b_i});
        mac_o = acc_i + $signed({{(ACC_W-2*D_W){prod[2*D_W-1]}}, prod});
        rnd   = ($signed({acc_i[ACC_W-1], acc_i}) + RND) >>> FRAC;
        if (rnd > SMAX)      q_o = SMAX[D_W-1:0];
        else if (rnd < SMIN) q_o = SMIN[D_W-1:0];
        else                 q_o = rnd[D_W-1:0];
    end
endmodule

module sa_tile_engine #(
    parameter int D_W   = 8,
    parameter int SA_R  = 16,
    parameter int SA_C  = 16,
    parameter int K_LEN = 128,
    parameter int FRAC  = 5
) (
    input  logic                                  I_CLK,
    input  logic                                  I_ASYN_RSTN,
    input  logic                                  I_SYNC_RSTN,
    input  logic                                  I_SA_START,
    input  logic [SA_R-1:0][K_LEN-1:0][D_W-1:0]   I_MAT_1,
    input  logic [K_LEN-1:0][SA_C-1:0][D_W-1:0]   I_MAT_2,
    output logic                                  O_PE_SHIFT,
    output logic                                  O_SA_VLD,
    output logic [SA_R-1:0][SA_C-1:0][D_W-1:0]    O_SA_RESULT
);
    localparam int ACC_W = 2 * D_W + $clog2(K_LEN);
    localparam int R_W   = (SA_R  > 1) ? $clog2(SA_R)  : 1;
    localparam int K_W   = (K_LEN > 1) ? $clog2(K_LEN) : 1;
    localparam logic [R_W-1:0] R_LAST = R_W'(SA_R - 1);
    localparam logic [K_W-1:0] K_LAST = K_W'(K_LEN - 1);

    typedef enum logic [1:0] {IDLE, CALC, WB} state_t;

    state_t                               state_q, state_d;
    logic [R_W-1:0]                       r_q, r_d;
    logic [K_W-1:0]                       k_q, k_d;
    logic [SA_C-1:0][ACC_W-1:0]           acc_q, acc_d;
    logic [SA_R-1:0][SA_C-1:0][D_W-1:0]   res_q, res_d;
    logic                                 vld_q, vld_d;
    logic                                 shift_q, shift_d;

    logic [D_W-1:0]                       a_elem;
    logic [SA_C-1:0][ACC_W-1:0]           acc_mac;
    logic [SA_C-1:0][D_W-1:0]             row_q;

    // A is shared by every column on a given cycle; B is indexed per column.
    assign a_elem = I_MAT_1[r_q][k_q];

    for (genvar c = 0; c < SA_C; c++) begin : g_col
        sa_tile_pe #(.D_W(D_W), .ACC_W(ACC_W), .FRAC(FRAC)) u_pe (
            .a_i   (a_elem),
            .b_i   (I_MAT_2[k_q][c]),
            .acc_i (acc_q[c]),
            .mac_o (acc_mac[c]),
            .q_o   (row_q[c])
        );
    end

    // Next-state logic; the synchronous reset overrides everything at the end.
    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        k_d     = k_q;
        acc_d   = acc_q;
        res_d   = res_q;
        vld_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (I_SA_START) begin
                    acc_d   = '0;
                    r_d     = '0;
                    k_d     = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                acc_d = acc_mac;
                if (k_q == K_LAST) begin
                    state_d = WB;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            WB: begin
                res_d[r_q] = row_q;
                acc_d      = '0;
                k_d        = '0;
                if (r_q == R_LAST) begin
                    vld_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    r_d     = r_q + 1'b1;
                    state_d = CALC;
                end
            end
            default: state_d = IDLE;
        endcase
        if (!I_SYNC_RSTN) begin
            state_d = IDLE;
            r_d     = '0;
            k_d     = '0;
            acc_d   = '0;
            res_d   = '0;
            vld_d   = 1'b0;
        end
        shift_d = (state_d == CALC);
    end

    // State and output registers with asynchronous clear.
    always_ff @(posedge I_CLK or negedge I_ASYN_RSTN) begin
        if (!I_ASYN_RSTN) begin
            state_q <= IDLE;
            r_q     <= '0;
            k_q     <= '0;
            acc_q   <= '0;
            res_q   <= '0;
            vld_q   <= 1'b0;
            shift_q <= 1'b0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            k_q     <= k_d;
            acc_q   <= acc_d;
            res_q   <= res_d;
            vld_q   <= vld_d;
            shift_q <= shift_d;
        end
    end

    assign O_PE_SHIFT  = shift_q;
    assign O_SA_VLD    = vld_q;
    assign O_SA_RESULT = res_q;
endmodule

// File: tb/tb_sa_tile_engine.sv
// Self-checking bench for sa_tile_engine: directed and random tiles compared
// against a plain matrix-product reference, plus timing and reset behaviour.
module tb_sa_tile_engine;
    localparam int D_W   = 8;
    localparam int SA_R  = 16;
    localparam int SA_C  = 16;
    localparam int K_LEN = 128;
    localparam int FRAC  = 5;
    localparam int LAT   = SA_R * (K_LEN + 1);

    logic I_CLK = 1'b0;
    logic I_ASYN_RSTN = 1'b1;
    logic I_SYNC_RSTN = 1'b1;
    logic I_SA_START = 1'b0;
    logic [SA_R-1:0][K_LEN-1:0][D_W-1:0] mat1 = '0;
    logic [K_LEN-1:0][SA_C-1:0][D_W-1:0] mat2 = '0;
    logic pe_shift, sa_vld;
    logic [SA_R-1:0][SA_C-1:0][D_W-1:0] res;

    int n_checks = 0;
    int n_err = 0;
    int cyc = 0;
    int exp_c [SA_R][SA_C];

    sa_tile_engine #(.D_W(D_W), .SA_R(SA_R), .SA_C(SA_C), .K_LEN(K_LEN), .FRAC(FRAC)) dut (
        .I_CLK       (I_CLK),
        .I_ASYN_RSTN (I_ASYN_RSTN),
        .I_SYNC_RSTN (I_SYNC_RSTN),
        .I_SA_START  (I_SA_START),
        .I_MAT_1     (mat1),
        .I_MAT_2     (mat2),
        .O_PE_SHIFT  (pe_shift),
        .O_SA_VLD    (sa_vld),
        .O_SA_RESULT (res)
    );

    always #5 I_CLK = ~I_CLK;
    always @(posedge I_CLK) cyc <= cyc + 1;

    function automatic void chk(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endfunction

    // Reference: integer dot products, round half up, clamp to the element range.
    function automatic void model();
        for (int r = 0; r < SA_R; r++)
            for (int c = 0; c < SA_C; c++) begin
                int s = 0;
                int q;
                for (int k = 0; k < K_LEN; k++)
                    s += int'($signed(mat1[r][k])) * int'($signed(mat2[k][c]));
                q = (s + (1 << (FRAC - 1))) >>> FRAC;
                if (q > 127) q = 127;
                if (q < -128) q = -128;
                exp_c[r][c] = q;
            end
    endfunction

    function automatic void zero_exp();
        for (int r = 0; r < SA_R; r++)
            for (int c = 0; c < SA_C; c++) exp_c[r][c] = 0;
    endfunction

    function automatic void check_tile(input string tag);
        int bad = 0;
        int fr = -1;
        int fc = -1;
        for (int r = 0; r < SA_R; r++)
            for (int c = 0; c < SA_C; c++)
                if (int'($signed(res[r][c])) != exp_c[r][c]) begin
                    if (bad == 0) begin fr = r; fc = c; end
                    bad++;
                end
        chk($sformatf("%s_tile_bad_elems(first r%0d c%0d)", tag, fr, fc), bad, 0);
    endfunction

    task automatic launch();
        I_SA_START = 1'b1;
        @(posedge I_CLK); #1;
        I_SA_START = 1'b0;
    endtask

    // Waits for VLD after a launch; optionally holds START high for a window.
    task automatic wait_vld(input int hold_from, input int hold_len, output int lat, output int shifts);
        lat = -1;
        shifts = pe_shift ? 1 : 0;
        for (int n = 1; n <= LAT + 200; n++) begin
            @(posedge I_CLK); #1;
            I_SA_START = (n >= hold_from && n < hold_from + hold_len);
            if (pe_shift) shifts++;
            if (sa_vld) begin
                lat = n;
                break;
            end
        end
        I_SA_START = 1'b0;
    endtask

    task automatic run_job(input string tag);
        int lat, shifts;
        model();
        @(negedge I_CLK);
        launch();
        wait_vld(0, 0, lat, shifts);
        chk({tag, "_latency"}, lat, LAT);
        chk({tag, "_shift_cycles"}, shifts, SA_R * K_LEN);
        check_tile(tag);
    endtask

    // One cycle after VLD: pulse gone, tile held in IDLE.
    task automatic after_vld(input string tag);
        @(posedge I_CLK); #1;
        chk({tag, "_vld_clears"}, int'(sa_vld), 0);
        check_tile({tag, "_hold"});
    endtask

    task automatic fill_rand(input int lo, input int hi);
        for (int r = 0; r < SA_R; r++)
            for (int k = 0; k < K_LEN; k++) mat1[r][k] = D_W'($urandom_range(hi - lo) + lo);
        for (int k = 0; k < K_LEN; k++)
            for (int c = 0; c < SA_C; c++) mat2[k][c] = D_W'($urandom_range(hi - lo) + lo);
    endtask

    initial begin
        int lat, shifts, v1, v2, nv;

        // Asynchronous reset state
        #2 I_ASYN_RSTN = 1'b0;
        #1;
        zero_exp();
        chk("rst_vld", int'(sa_vld), 0);
        chk("rst_shift", int'(pe_shift), 0);
        check_tile("rst");
        @(negedge I_CLK); I_ASYN_RSTN = 1'b1;
        repeat (2) @(negedge I_CLK);

        // Identity-scaled A, B all 7
        for (int r = 0; r < SA_R; r++)
            for (int k = 0; k < K_LEN; k++) mat1[r][k] = (r == k) ? 8'd32 : 8'd0;
        mat2 = {(K_LEN*SA_C){8'd7}};
        run_job("diag");
        chk("diag_c00", int'($signed(res[0][0])), 7);
        after_vld("diag");

        // Saturation both ways
        mat1 = {(SA_R*K_LEN){8'd127}};
        mat2 = {(K_LEN*SA_C){8'd127}};
        run_job("sat_pos");
        chk("sat_pos_c55", int'($signed(res[5][5])), 127);
        mat2 = {(K_LEN*SA_C){8'h80}};
        run_job("sat_neg");
        chk("sat_neg_c33", int'($signed(res[3][3])), -128);

        // Rounding boundaries on a single product
        mat1 = '0;
        mat2 = '0;
        mat1[0][0] = 8'd1;
        mat2[0][0] = 8'd16;
        run_job("rnd16");
        chk("rnd16_c00", int'($signed(res[0][0])), 1);
        mat2[0][0] = 8'd15;
        run_job("rnd15");
        chk("rnd15_c00", int'($signed(res[0][0])), 0);
        mat2[0][0] = 8'hF0;
        run_job("rndm16");
        chk("rndm16_c00", int'($signed(res[0][0])), 0);

        // START held high mid-job: ignored, single VLD
        fill_rand(-4, 3);
        model();
        @(negedge I_CLK);
        launch();
        wait_vld(300, 500, lat, shifts);
        chk("hold_latency", lat, LAT);
        chk("hold_shift_cycles", shifts, SA_R * K_LEN);
        check_tile("hold");
        nv = 0;
        for (int n = 0; n < 100; n++) begin
            @(posedge I_CLK); #1;
            if (sa_vld || pe_shift) nv++;
        end
        chk("hold_no_restart", nv, 0);

        // Back-to-back: restart in the VLD cycle with new operands
        fill_rand(-128, 127);
        run_job("b2b_first");
        v1 = cyc;
        fill_rand(-8, 7);
        model();
        launch();
        wait_vld(0, 0, lat, shifts);
        v2 = cyc;
        chk("b2b_vld_spacing", v2 - v1, LAT + 1);
        check_tile("b2b_second");

        // Synchronous reset mid-job
        fill_rand(-16, 15);
        @(negedge I_CLK);
        launch();
        repeat (999) begin @(posedge I_CLK); #1; end
        I_SYNC_RSTN = 1'b0;
        @(posedge I_CLK); #1;
        I_SYNC_RSTN = 1'b1;
        zero_exp();
        chk("srst_vld", int'(sa_vld), 0);
        chk("srst_shift", int'(pe_shift), 0);
        check_tile("srst");
        nv = 0;
        for (int n = 0; n < LAT + 100; n++) begin
            @(posedge I_CLK); #1;
            if (sa_vld) nv++;
        end
        chk("srst_no_vld", nv, 0);
        run_job("srst_recover");

        // Asynchronous reset mid-job, between edges
        @(negedge I_CLK);
        launch();
        repeat (500) begin @(posedge I_CLK); #1; end
        #2 I_ASYN_RSTN = 1'b0;
        #1;
        zero_exp();
        chk("arst_vld", int'(sa_vld), 0);
        chk("arst_shift", int'(pe_shift), 0);
        check_tile("arst");
        @(negedge I_CLK); I_ASYN_RSTN = 1'b1;
        fill_rand(-32, 31);
        run_job("arst_recover");
        after_vld("arst_recover");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule

// File: doc/sa_tile_engine.md
SA_TILE_ENGINE -- requirements
Module: sa_tile_engine

Interface
REQ-001 Parameter D_W, default 8: element width, signed two's complement.
REQ-002 Parameter SA_R, default 16: result tile rows.
REQ-003 Parameter SA_C, default 16: result tile columns.
REQ-004 Parameter K_LEN, default 128: inner (reduction) dimension.
REQ-005 Parameter FRAC, default 5: fractional bits of the fixed-point format (32 = 1.0).
REQ-006 I_CLK  in  1  clock; I_ASYN_RSTN  in  1  reset, asynchronous, active-low.
REQ-007 I_SYNC_RSTN  in  1  synchronous reset, active-low.
REQ-008 I_SA_START  in  1  job request, sampled only in IDLE.
REQ-009 I_MAT_1  in  [SA_R][K_LEN] x D_W  left operand A.
REQ-010 I_MAT_2  in  [K_LEN][SA_C] x D_W  right operand B.
REQ-011 O_PE_SHIFT  out  1  high on every accumulate cycle.
REQ-012 O_SA_VLD  out  1  one-cycle pulse, result tile complete.
REQ-013 O_SA_RESULT  out  [SA_R][SA_C] x D_W  result tile C = A*B, quantized.

Function
REQ-014 The block SHALL be the responder for the attention controller: it computes C[r][c] = sum over k of A[r][k]*B[k][c].
REQ-015 States SHALL be IDLE, CALC and WB; there are no others.
REQ-016 IDLE with I_SA_START=1 at an edge: clear SA_C accumulators, set r=0, k=0, go to CALC; otherwise stay in IDLE.
REQ-017 Each CALC edge: acc[c] += A[r][k]*B[k][c] for all c in parallel; k++; at k=K_LEN-1, go to WB.
REQ-018 Accumulators SHALL be signed, 2*D_W+log2(K_LEN) bits (23 at defaults), with no internal overflow.
REQ-019 WB edge: write row r of O_SA_RESULT = sat(round(acc[c])); clear accumulators; k=0; if r=SA_R-1, go to IDLE, else r++ and go to CALC.
REQ-020 round(x) SHALL be (x + 2^(FRAC-1)) arithmetic-shifted right by FRAC (round half up).
REQ-021 sat SHALL clamp to [-2^(D_W-1), 2^(D_W-1)-1], i.e. [-128, 127] at defaults.
REQ-022 O_PE_SHIFT SHALL equal (state==CALC), giving exactly SA_R*K_LEN high cycles per job.
REQ-023 O_SA_VLD SHALL be registered and set by the final WB edge, so the complete tile and VLD are visible in the same cycle; it clears at the next edge.
REQ-024 Latency: start sampled at edge t0 gives O_SA_VLD high in the cycle after edge t0 + SA_R*(K_LEN+1), i.e. t0+2064 at defaults.
REQ-025 I_SA_START SHALL be ignored outside IDLE; there is no queuing.
REQ-026 A start asserted during the O_SA_VLD cycle (state IDLE) SHALL be accepted, allowing back-to-back jobs.
REQ-027 I_MAT_1 and I_MAT_2 are not latched; the initiator holds them stable from the start edge to O_SA_VLD, and results are undefined otherwise.
REQ-028 O_SA_RESULT rows SHALL update only on their WB edge and hold otherwise, including in IDLE.

Reset
REQ-029 Asserting I_ASYN_RSTN low SHALL immediately force state IDLE, r=0, k=0, accumulators=0, O_SA_VLD=0, O_PE_SHIFT=0, O_SA_RESULT all zero.
REQ-030 I_SYNC_RSTN=0 at an edge SHALL produce the same values as REQ-029, in any state; a mid-job reset abandons the job with no O_SA_VLD.

Verification
REQ-031 A[r][r]=32, others 0; B all 7 -> every C=7; VLD 2064 cycles after the start edge; 2048 O_PE_SHIFT cycles.
REQ-032 A all 127, B all 127 -> every C=127 (saturation); B all -128 -> every C=-128.
REQ-033 Only A[0][0]=1, B[0][0]=16 -> C[0][0]=1; B[0][0]=15 -> C[0][0]=0; B[0][0]=-16 -> C[0][0]=0; all other C=0.
REQ-034 I_SA_START held high for 500 cycles mid-job -> single VLD at the original t0+2064, with no restart.
REQ-035 I_SYNC_RSTN low for 1 cycle at t0+1000 -> outputs zero, no VLD; a new start then completes normally.
REQ-036 Start asserted in the VLD cycle with new operands -> second VLD exactly 2065 cycles after the first, with the correct new tile.
